bus_xfer_ctrl: RTL

//  Destination-side controller for the 32-bit shared datapath bus. Takes one transfer request (source id, destination id),

---
 rtl/bus_xfer_ctrl_if.sv | 36 +++
 rtl/bus_xfer_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bus_xfer_ctrl_if.sv
// ---------------------------------------------------------------------------
// bus_xfer_ctrl_if
// Handshake and enable bundle between the control unit (master) and the
// bus transfer controller (slave).
//   start       : request a transfer (master -> slave)
//   src_sel     : 5-bit source id      (master -> slave)
//   dst_sel     : 5-bit destination id (master -> slave)
//   src_out_en  : one-hot source out-enable toward the bus mux (slave -> master)
//   dst_in_en   : one-hot destination in-enable               (slave -> master)
//   busy        : transfer in progress                         (slave -> master)
//   done        : one-cycle completion pulse                   (slave -> master)
//   err         : one-cycle rejected-request pulse             (slave -> master)
// ---------------------------------------------------------------------------
interface bus_xfer_ctrl_if #(
    parameter int NUM_SRC = 24,
    parameter int NUM_DST = 24
);
    logic               start;
    logic [4:0]         src_sel;
    logic [4:0]         dst_sel;
    logic [NUM_SRC-1:0] src_out_en;
    logic [NUM_DST-1:0] dst_in_en;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output start, src_sel, dst_sel,
        input  src_out_en, dst_in_en, busy, done, err
    );

    modport slave (
        input  start, src_sel, dst_sel,
        output src_out_en, dst_in_en, busy, done, err
    );
endinterface

// File: rtl/bus_xfer_ctrl.sv
// ---------------------------------------------------------------------------
// bus_xfer_ctrl
// Destination-side controller for the shared 32-bit datapath bus. Accepts
// one (source, destination) transfer request, drives a single source
// out-enable, holds it alone for SETTLE_CYCLES cycles, then pulses a single
// destination in-enable for one cycle so the target captures BusMuxOut.
// Ports:
//   clock : system clock (rising edge)
//   clear : synchronous active-high reset
//   bus   : bus_xfer_ctrl_if.slave (start/src_sel/dst_sel in;
//           src_out_en/dst_in_en/busy/done/err out, all registered)
// ---------------------------------------------------------------------------
module bus_xfer_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int NUM_SRC       = 24,
    parameter int NUM_DST       = 24
) (
    input  logic            clock,
    input  logic            clear,
    bus_xfer_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [5:0] SRC_LIMIT = 6'(NUM_SRC);
    localparam logic [5:0] DST_LIMIT = 6'(NUM_DST);
    // Terminal count of the settle counter; unused when SETTLE_CYCLES is 0
    // because SETTLE is then skipped entirely.
    localparam logic [3:0] LAST_CNT  = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;

    state_t             state_reg, state_next;
    logic [4:0]         src_id_reg, src_id_next;
    logic [4:0]         dst_id_reg, dst_id_next;
    logic [3:0]         cnt_reg, cnt_next;

    logic [NUM_SRC-1:0] src_en_reg, src_en_next;
    logic [NUM_DST-1:0] dst_en_reg, dst_en_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               err_reg, err_next;

    logic [NUM_SRC-1:0] src_dec;
    logic [NUM_DST-1:0] dst_dec;
    logic               req_valid;

    assign req_valid = ({1'b0, bus.src_sel} < SRC_LIMIT) &&
                       ({1'b0, bus.dst_sel} < DST_LIMIT);

    // Decoders work on the *next* latched ids so the registered enables line
    // up with the state they belong to (outputs are a registered decode of
    // state_next rather than a combinational decode of state_reg).
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src_dec
            assign src_dec[gi] = (src_id_next == 5'(gi));
        end
        for (gi = 0; gi < NUM_DST; gi++) begin : g_dst_dec
            assign dst_dec[gi] = (dst_id_next == 5'(gi));
        end
    endgenerate

    // Next-state logic
    always_comb begin
        state_next  = state_reg;
        src_id_next = src_id_reg;
        dst_id_next = dst_id_reg;
        cnt_next    = cnt_reg;
        err_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    if (req_valid) begin
                        src_id_next = bus.src_sel;
                        dst_id_next = bus.dst_sel;
                        cnt_next    = 4'd0;
                        state_next  = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (cnt_reg == LAST_CNT) begin
                    cnt_next   = 4'd0;
                    state_next = ST_CAPTURE;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            ST_CAPTURE: state_next = ST_DONE;
            ST_DONE:    state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Output decode of the state being entered
    always_comb begin
        src_en_next = '0;
        dst_en_next = '0;
        busy_next   = (state_next != ST_IDLE);
        done_next   = (state_next == ST_DONE);
        if ((state_next == ST_SETTLE) || (state_next == ST_CAPTURE)) begin
            src_en_next = src_dec;
        end
        if (state_next == ST_CAPTURE) begin
            dst_en_next = dst_dec;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg  <= ST_IDLE;
            src_id_reg <= '0;
            dst_id_reg <= '0;
            cnt_reg    <= '0;
            src_en_reg <= '0;
            dst_en_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            src_id_reg <= src_id_next;
            dst_id_reg <= dst_id_next;
            cnt_reg    <= cnt_next;
            src_en_reg <= src_en_next;
            dst_en_reg <= dst_en_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    assign bus.src_out_en = src_en_reg;
    assign bus.dst_in_en  = dst_en_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.err        = err_reg;

endmodule
